// File: rtl/foo_rtl_rr_scheduler_pkg.sv
// Shared types, default parameters and small index helpers for the
// round-robin scheduler that fronts one foo_RTL datapath instance.
package foo_rtl_sched_pkg;

    // Scheduler FSM encoding; the values are visible to the bound monitor.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } sched_state_e;

    localparam int DEF_N_REQ   = 3;
    localparam int DEF_WIDTH   = 5;
    localparam int DEF_TIMEOUT = 16;

    // Width needed to hold an index in 0..n-1, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Requester index reached by stepping 'off' places from 'base' in a ring of n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/foo_rtl_rr_scheduler_if.sv
// Requester and datapath handshake bundle of the scheduler.
// 'slave' is the scheduler's view, 'master' is the view of the requesters
// and the datapath stand-in that surround it.
interface foo_rtl_rr_scheduler_if
    import foo_rtl_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);

    // Requester side: packed lanes, lane i operands at [i*WIDTH +: WIDTH].
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_in1;
    logic [N_REQ*WIDTH-1:0] req_in2;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic                   rsp_data;
    logic                   rsp_err;

    // Datapath side.
    logic                   dp_valid;
    logic                   dp_ready;
    logic [WIDTH-1:0]       dp_in1;
    logic [WIDTH-1:0]       dp_in2;
    logic                   dp_rsp_valid;
    logic                   dp_rsp_data;

    modport slave (
        input  req_valid, req_in1, req_in2, rsp_ready,
        input  dp_ready, dp_rsp_valid, dp_rsp_data,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output dp_valid, dp_in1, dp_in2
    );

    modport master (
        output req_valid, req_in1, req_in2, rsp_ready,
        output dp_ready, dp_rsp_valid, dp_rsp_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  dp_valid, dp_in1, dp_in2
    );

endinterface

// File: rtl/foo_rr_pick.sv
// Combinational rotate-priority picker: the first set bit of 'req' found
// when scanning ptr, ptr+1, ... (mod N) wins. Shared with the monitor's
// reference model so both agree on the arbitration order.
module foo_rr_pick
    import foo_rtl_sched_pkg::*;
#(
    parameter int N     = DEF_N_REQ,
    parameter int IDX_W = id_width(DEF_N_REQ)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // One-hot vector with only bit j set.
    function automatic logic [N-1:0] lane_bit(input int j);
        logic [N-1:0] v;
        v    = '0;
        v[j] = 1'b1;
        return v;
    endfunction

    // Scan from the farthest offset to the nearest so the requester closest to ptr is written last and wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr), k, N)]) begin
                onehot = lane_bit(wrap_idx(int'(ptr), k, N));
                idx    = IDX_W'(wrap_idx(int'(ptr), k, N));
                any    = 1'b1;
            end else begin
                any    = any;
            end
        end
    end

endmodule

// File: rtl/foo_rtl_rr_scheduler.sv
// Round-robin scheduler sharing one foo_RTL datapath between N_REQ
// ready/valid requesters. One transaction in flight: grant, issue the
// latched operands, wait for the result (bounded by TIMEOUT), deliver it
// to the winner. Sticky error flags and busy/grant_id feed the monitor.
module foo_rtl_rr_scheduler
    import foo_rtl_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = id_width(N_REQ),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    foo_rtl_rr_scheduler_if.slave  bus,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err,
    output logic                   spurious_err
);

    // The timer only has to reach TIMEOUT-1 before the abort fires.
    localparam int TMR_W = id_width(TIMEOUT);

    sched_state_e       state_r;
    sched_state_e       state_nxt_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    grant_id_r;
    logic [TMR_W-1:0]   timer_r;
    logic [WIDTH-1:0]   dp_in1_r;
    logic [WIDTH-1:0]   dp_in2_r;
    logic               rsp_data_r;
    logic               rsp_err_r;
    logic               timeout_err_r;
    logic               spurious_err_r;

    logic [N_REQ-1:0]   pick_onehot_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic               pick_any_s;
    logic [WIDTH-1:0]   win_in1_s;
    logic [WIDTH-1:0]   win_in2_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic [N_REQ-1:0]   rsp_valid_s;
    logic               rsp_ready_gnt_s;
    logic               timer_hit_s;

    foo_rr_pick #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign timer_hit_s = (timer_r == TMR_W'(TIMEOUT - 1));

    // Operand mux for the current winner; an AND-OR tree keeps it a pure function of the one-hot grant.
    always_comb begin
        win_in1_s = '0;
        win_in2_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_in1_s = win_in1_s | (bus.req_in1[i*WIDTH +: WIDTH] & {WIDTH{pick_onehot_s[i]}});
            win_in2_s = win_in2_s | (bus.req_in2[i*WIDTH +: WIDTH] & {WIDTH{pick_onehot_s[i]}});
        end
    end

    // Handshake decode: accept only in IDLE and never while reset is asserted; deliver only to the granted lane.
    always_comb begin
        req_ready_s = pick_onehot_s & {N_REQ{(state_r == IDLE) && ASYNCRESETN}};
        rsp_valid_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_s[i] = (state_r == DELIVER) && (int'(grant_id_r) == i);
        end
        rsp_ready_gnt_s = |(bus.rsp_ready & rsp_valid_s);
    end

    // Next-state logic of the grant/issue/wait/deliver sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) state_nxt_s = ISSUE;
                else            state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (bus.dp_ready) state_nxt_s = WAIT_RSP;
                else              state_nxt_s = ISSUE;
            end
            WAIT_RSP: begin
                if (bus.dp_rsp_valid || timer_hit_s) state_nxt_s = DELIVER;
                else                                 state_nxt_s = WAIT_RSP;
            end
            DELIVER: begin
                if (rsp_ready_gnt_s) state_nxt_s = IDLE;
                else                 state_nxt_s = DELIVER;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Transaction bookkeeping: operand latch, grant id, response timer, result capture and pointer advance.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            timer_r    <= '0;
            dp_in1_r   <= '0;
            dp_in2_r   <= '0;
            rsp_data_r <= 1'b0;
            rsp_err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        dp_in1_r   <= win_in1_s;
                        dp_in2_r   <= win_in2_s;
                        grant_id_r <= pick_idx_s;
                    end
                end
                ISSUE: begin
                    if (bus.dp_ready) begin
                        timer_r <= '0;
                    end
                end
                WAIT_RSP: begin
                    timer_r <= timer_r + TMR_W'(1);
                    // A response arriving on the final timer cycle still counts as a real result.
                    if (bus.dp_rsp_valid) begin
                        rsp_data_r <= bus.dp_rsp_data;
                        rsp_err_r  <= 1'b0;
                    end else if (timer_hit_s) begin
                        rsp_data_r <= 1'b0;
                        rsp_err_r  <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (rsp_ready_gnt_s) begin
                        rr_ptr_r   <= ID_W'(wrap_idx(int'(grant_id_r), 1, N_REQ));
                        grant_id_r <= '0;
                    end
                end
                default: begin
                    grant_id_r <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            timeout_err_r  <= 1'b0;
            spurious_err_r <= 1'b0;
        end else begin
            if ((state_r == WAIT_RSP) && !bus.dp_rsp_valid && timer_hit_s) begin
                timeout_err_r <= 1'b1;
            end
            // Any strobe outside WAIT_RSP is dropped; this also catches a result arriving after a timeout.
            if (bus.dp_rsp_valid && (state_r != WAIT_RSP)) begin
                spurious_err_r <= 1'b1;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.dp_valid  = (state_r == ISSUE);
    assign bus.dp_in1    = dp_in1_r;
    assign bus.dp_in2    = dp_in2_r;
    assign busy          = (state_r != IDLE);
    assign grant_id      = grant_id_r;
    assign timeout_err   = timeout_err_r;
    assign spurious_err  = spurious_err_r;

endmodule

// File: tb/tb_foo_rtl_rr_scheduler.sv
// Self-checking bench for foo_rtl_rr_scheduler. The bench plays all three
// requesters and the datapath (result = in1 > in2). Expected responses are
// queued when a request is accepted and retired when rsp_valid appears.
module tb_foo_rtl_rr_scheduler;

    localparam int N   = 3;
    localparam int W   = 5;
    localparam int IDW = 2;
    localparam int TMO = 16;

    typedef struct {
        int   lane;
        logic data;
        logic err;
    } exp_t;

    logic           CLK = 1'b0;
    logic           ASYNCRESETN;
    logic           busy;
    logic [IDW-1:0] grant_id;
    logic           timeout_err;
    logic           spurious_err;

    foo_rtl_rr_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

    foo_rtl_rr_scheduler #(
        .N_REQ   (N),
        .WIDTH   (W),
        .ID_W    (IDW),
        .TIMEOUT (TMO)
    ) dut (
        .CLK          (CLK),
        .ASYNCRESETN  (ASYNCRESETN),
        .bus          (bus),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err),
        .spurious_err (spurious_err)
    );

    always #5 CLK = ~CLK;

    int         n_vec  = 0;
    int         n_err  = 0;
    int         tb_ptr = 0;
    exp_t       sb_q[$];
    logic [W-1:0] op1 [N];
    logic [W-1:0] op2 [N];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic dp_model(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? 1'b1 : 1'b0;
    endfunction

    function automatic int exp_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_in1[i*W +: W] = op1[i];
            bus.req_in2[i*W +: W] = op2[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op1[i] = W'($urandom_range(0, 31));
            op2[i] = W'($urandom_range(0, 31));
        end
    endtask

    // One full transaction. rsp_lat < 0 means the datapath never answers.
    // abort_at >= 0 pulses reset in that WAIT_RSP cycle and abandons the transaction.
    task automatic txn(input logic [N-1:0] vmask, input int issue_stall, input int rsp_lat,
                       input int dlv_stall, input int abort_at);
        int           w;
        int           wait_cyc;
        exp_t         e;
        exp_t         got_e;
        logic [N-1:0] lane_oh;
        logic [N-1:0] got_oh;
        w          = exp_winner(vmask, tb_ptr);
        lane_oh    = '0;
        lane_oh[w] = 1'b1;
        drive_ops();
        bus.req_valid    = vmask;
        bus.dp_ready     = 1'b0;
        bus.rsp_ready    = '0;
        bus.dp_rsp_valid = 1'b0;
        sample();
        check_val("idle_grant_id", 32'(grant_id), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("req_ready", 32'(bus.req_ready), 32'(lane_oh));
        e.lane = w;
        e.err  = (rsp_lat < 0) ? 1'b1 : 1'b0;
        e.data = (rsp_lat < 0) ? 1'b0 : dp_model(op1[w], op2[w]);
        sb_q.push_back(e);
        step();
        for (int s = 0; s <= issue_stall; s++) begin
            bus.dp_ready = (s == issue_stall);
            sample();
            check_val("dp_valid", 32'(bus.dp_valid), 32'd1);
            check_val("dp_in1", 32'(bus.dp_in1), 32'(op1[w]));
            check_val("dp_in2", 32'(bus.dp_in2), 32'(op2[w]));
            check_val("issue_req_ready", 32'(bus.req_ready), 32'd0);
            check_val("issue_busy", 32'(busy), 32'd1);
            check_val("issue_grant_id", 32'(grant_id), 32'(w));
            step();
        end
        bus.dp_ready = 1'b0;
        wait_cyc = (rsp_lat >= 0 && rsp_lat < TMO) ? rsp_lat + 1 : TMO;
        for (int c = 0; c < wait_cyc; c++) begin
            if (c == abort_at) begin
                ASYNCRESETN = 1'b0;
                #1;
                check_val("abort_busy", 32'(busy), 32'd0);
                check_val("abort_grant_id", 32'(grant_id), 32'd0);
                check_val("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check_val("abort_dp_valid", 32'(bus.dp_valid), 32'd0);
                check_val("abort_req_ready", 32'(bus.req_ready), 32'd0);
                check_val("abort_dp_in1", 32'(bus.dp_in1), 32'd0);
                check_val("abort_timeout_err", 32'(timeout_err), 32'd0);
                check_val("abort_spurious_err", 32'(spurious_err), 32'd0);
                void'(sb_q.pop_back());
                @(posedge CLK);
                #1;
                ASYNCRESETN = 1'b1;
                bus.req_valid = '0;
                tb_ptr = 0;
                return;
            end
            bus.dp_rsp_valid = (c == rsp_lat);
            bus.dp_rsp_data  = dp_model(bus.dp_in1, bus.dp_in2);
            sample();
            check_val("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check_val("wait_dp_valid", 32'(bus.dp_valid), 32'd0);
            check_val("wait_req_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        bus.dp_rsp_valid = 1'b0;
        bus.dp_rsp_data  = 1'b0;
        for (int s = 0; s <= dlv_stall; s++) begin
            bus.rsp_ready = (s == dlv_stall) ? lane_oh : ~lane_oh;
            sample();
            check_val("dlv_req_ready", 32'(bus.req_ready), 32'd0);
            check_val("dlv_busy", 32'(busy), 32'd1);
            if ((bus.rsp_valid != '0) && (sb_q.size() != 0)) begin
                if (s == dlv_stall) got_e = sb_q.pop_front();
                else                got_e = sb_q[0];
                got_oh             = '0;
                got_oh[got_e.lane] = 1'b1;
                check_val("rsp_valid", 32'(bus.rsp_valid), 32'(got_oh));
                check_val("rsp_data", 32'(bus.rsp_data), 32'(got_e.data));
                check_val("rsp_err", 32'(bus.rsp_err), 32'(got_e.err));
            end else begin
                check_val("rsp_valid_missing", 32'(bus.rsp_valid), 32'(lane_oh));
            end
            step();
        end
        bus.rsp_ready = '0;
        bus.req_valid = '0;
        tb_ptr = (w + 1) % N;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: no finish after %0t", $time);
        $fatal(1);
    end

    initial begin
        ASYNCRESETN      = 1'b0;
        bus.req_valid    = '1;
        bus.req_in1      = '0;
        bus.req_in2      = '0;
        bus.rsp_ready    = '0;
        bus.dp_ready     = 1'b0;
        bus.dp_rsp_valid = 1'b0;
        bus.dp_rsp_data  = 1'b0;
        rand_ops();
        repeat (2) @(posedge CLK);
        sample();
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_grant_id", 32'(grant_id), 32'd0);
        check_val("rst_dp_valid", 32'(bus.dp_valid), 32'd0);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check_val("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_val("rst_dp_in1", 32'(bus.dp_in1), 32'd0);
        check_val("rst_dp_in2", 32'(bus.dp_in2), 32'd0);
        check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_val("rst_spurious_err", 32'(spurious_err), 32'd0);
        step();
        ASYNCRESETN   = 1'b1;
        bus.req_valid = '0;

        // Fairness from reset: all lanes requesting, grants must rotate 0,1,2,...
        for (int t = 0; t < 12; t++) begin
            rand_ops();
            txn(3'b111, 0, t % 2, 0, -1);
        end

        // Single request at minimum latency, then all lanes to confirm the pointer moved to 2.
        op1[1] = 5'h1F;
        op2[1] = 5'h03;
        txn(3'b010, 0, 0, 0, -1);
        rand_ops();
        txn(3'b111, 0, 0, 0, -1);

        // Backpressure on both the datapath and the response side.
        rand_ops();
        txn(3'b101, 5, 1, 4, -1);

        // Response on the same cycle the timer expires: result wins, no error.
        op1[1] = 5'h10;
        op2[1] = 5'h02;
        txn(3'b011, 0, TMO - 1, 0, -1);
        sample();
        check_val("coinc_timeout_err", 32'(timeout_err), 32'd0);
        step();

        // Full timeout, then a late datapath strobe while idle.
        rand_ops();
        txn(3'b111, 0, -1, 0, -1);
        sample();
        check_val("tmo_timeout_err", 32'(timeout_err), 32'd1);
        check_val("tmo_spurious_pre", 32'(spurious_err), 32'd0);
        step();
        bus.dp_rsp_valid = 1'b1;
        bus.dp_rsp_data  = 1'b1;
        sample();
        check_val("late_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        bus.dp_rsp_valid = 1'b0;
        bus.dp_rsp_data  = 1'b0;
        sample();
        check_val("late_spurious_err", 32'(spurious_err), 32'd1);
        check_val("late_busy", 32'(busy), 32'd0);
        step();

        // Move the pointer off zero, abort a transaction by reset, then all lanes must restart at lane 0.
        rand_ops();
        txn(3'b001, 0, 0, 0, -1);
        rand_ops();
        txn(3'b111, 0, -1, 0, 3);
        rand_ops();
        txn(3'b111, 0, 2, 1, -1);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/foo_rtl_rr_scheduler.md
Name: foo_rtl_rr_scheduler

Overview:
- Shares one foo_RTL datapath instance (operands in1/in2, 1-bit result out) between N_REQ ready/valid requesters.
- One transaction is in flight at a time: grant, issue, wait for the result, return the result to the winner.
- Round-robin fairness; a response timeout with sticky error flags; a busy/grant-id observation port for the bound monitor.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WIDTH, 5, operand width of in1/in2.
- ID_W, 2, grant-id width; must equal clog2(N_REQ), minimum 1.
- TIMEOUT, 16, maximum cycles in WAIT_RSP before abort (>=2).

Ports:
- CLK  in  1  clock, all state on rising edge.
- ASYNCRESETN  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, at most one bit set.
- req_in1  in  N_REQ*WIDTH  operand 1, requester i at bits [i*WIDTH +: WIDTH].
- req_in2  in  N_REQ*WIDTH  operand 2, same packing.
- rsp_valid  out  N_REQ  per-requester result valid, at most one bit set.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  1  result bit, shared by all requesters.
- rsp_err  out  1  result was produced by timeout; qualified by any rsp_valid.
- dp_valid  out  1  operands valid to the datapath.
- dp_ready  in  1  datapath accepts operands.
- dp_in1, dp_in2  out  WIDTH  latched operands.
- dp_rsp_valid  in  1  datapath result strobe.
- dp_rsp_data  in  1  datapath result (out).
- busy  out  1  state != IDLE.
- grant_id  out  ID_W  id of the current transaction; 0 when idle.
- timeout_err  out  1  sticky; set on any timeout.
- spurious_err  out  1  sticky; set on dp_rsp_valid outside WAIT_RSP.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, rr_ptr=0, grant_id=0, timer=0.
  - Operand and result registers cleared to 0.
  - req_ready=0, rsp_valid=0, dp_valid=0, rsp_data=0, rsp_err=0, busy=0, timeout_err=0, spurious_err=0.
- Reset mid-transaction aborts it silently: no rsp_valid is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT_RSP, DELIVER.
- IDLE:
  - Winner = first i with req_valid[i] in order rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready[winner]=1, combinational from req_valid and rr_ptr.
  - On that edge: latch req_in1/req_in2 of the winner into dp_in1/dp_in2, grant_id<=winner, go to ISSUE.
  - No req_valid: stay in IDLE, all req_ready=0.
- ISSUE:
  - dp_valid=1.
  - On dp_ready, go to WAIT_RSP and clear timer.
  - dp_in1/dp_in2 are stable while dp_valid is high.
- WAIT_RSP:
  - timer increments each cycle.
  - dp_rsp_valid: capture rsp_data<=dp_rsp_data, rsp_err<=0, go to DELIVER.
  - Else if timer==TIMEOUT-1: rsp_data<=0, rsp_err<=1, timeout_err<=1, go to DELIVER.
  - If dp_rsp_valid and timeout coincide, the response wins; no error is flagged.
- DELIVER:
  - rsp_valid[grant_id]=1.
  - On rsp_ready[grant_id]: rr_ptr<=(grant_id+1) mod N_REQ, go to IDLE.
  - rsp_ready on non-granted lanes is ignored.
- dp_rsp_valid in IDLE, ISSUE or DELIVER is dropped and sets spurious_err. A late response after a timeout is caught this way.
- req_ready is 0 in every state except IDLE. A request held valid waits and its operands are sampled only when accepted.
- Minimum latency: request accept at cycle 0, dp_valid at cycle 1, dp_rsp_valid at cycle 2 earliest, rsp_valid at cycle 3. Back-to-back issue every 4 cycles.
- rr_ptr wraps N_REQ-1 -> 0.
- rr_ptr updates only on delivery. An aborting reset leaves rr_ptr at 0.
- Sticky flags clear only on reset.

Decomposition:
- Package foo_rtl_sched_pkg:
  - state enum (IDLE=0, ISSUE=1, WAIT_RSP=2, DELIVER=3, 2 bits).
  - Default N_REQ/WIDTH/TIMEOUT constants.
  - clog2-based ID_W helper.
- Sub-module foo_rr_pick:
  - Combinational rotate-priority picker: req vector + ptr in, onehot + index + any out.
  - Reused by the monitor's reference model.
- Timer and FSM stay in the top.

Test Plan:
- Single request: req_valid=3'b010, in1=5'h1F, in2=5'h03; datapath ready immediately, responds 1 cycle later with 1. Required: req_ready[1] at cycle 0, dp_valid cycle 1 with dp_in1=1F/dp_in2=03, rsp_valid[1] cycle 3 with rsp_data=1, rsp_err=0, grant_id=1; rr_ptr=2 afterward.
- Fairness: all three req_valid held high for 12 transactions from reset. Required: grant order 0,1,2,0,1,2,...; no lane granted twice before the others are granted.
- Backpressure: dp_ready low for 5 cycles in ISSUE; rsp_ready low for 4 cycles in DELIVER. Required: dp_in1/dp_in2, rsp_valid and rsp_data stable throughout; no req_ready asserted; busy=1.
- Timeout: TIMEOUT=16, no dp_rsp_valid. Required: DELIVER entered exactly 16 cycles after the dp_ready handshake; rsp_data=0, rsp_err=1, timeout_err=1. A late dp_rsp_valid afterward sets spurious_err=1.
- Coincidence: dp_rsp_valid=1, dp_rsp_data=1 on the timer==TIMEOUT-1 cycle. Required: rsp_data=1, rsp_err=0, timeout_err remains 0.
- Reset mid-WAIT_RSP: ASYNCRESETN low for 1 cycle. Required: outputs zero immediately (asynchronous), no rsp_valid, grant_id=0, next grant follows rr_ptr=0 priority.
